// File: rtl/sd_write_photo.sv
// Streams one RGB565 frame as a 24-bit bottom-up BMP file into single-sector SD writes.
// Optional build macro SD_WR_TESTPAT_EN replaces FIFO pixels with an 8-column colour bar.
module sd_write_photo #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] sec_base,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic [15:0] wr_data,
    output logic        pix_rd_en,
    input  logic [15:0] pix_data,
    input  logic        pix_empty,
    output logic        busy,
    output logic        done,
    output logic        err_underflow
);

    localparam int PIX_BYTES  = IMG_W * IMG_H * 3;
    localparam int FILE_BYTES = 54 + PIX_BYTES;
    localparam int SEC_NUM    = (FILE_BYTES + 511) / 512;
    localparam int PIX_WORDS  = PIX_BYTES / 2;
    localparam int PAIR_NUM   = IMG_W * IMG_H / 2;

    localparam logic [31:0] FB32     = 32'(FILE_BYTES);
    localparam logic [31:0] PB32     = 32'(PIX_BYTES);
    localparam logic [31:0] W32      = 32'(IMG_W);
    localparam logic [31:0] H32      = 32'(IMG_H);
    localparam logic [31:0] PIX_END  = 32'(27 + PIX_WORDS);
    localparam logic [31:0] LAST_SEC = 32'(SEC_NUM - 1);
    localparam logic [31:0] LAST_PR  = 32'(PAIR_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_XFER, S_WAIT, S_DONE} state_t;

    state_t      state, next_state;
    logic [31:0] sec_cnt;
    logic [7:0]  wcnt;
    logic [31:0] w;
    logic [1:0]  ph;
    logic [31:0] pair_cnt;
    logic [1:0]  fetch_cnt;
    logic [15:0] stg0, stg1;
    logic        busy_d1, busy_d2;
    logic [15:0] hdr_word, word_val;

    logic accept_req, busy_fall, last_sec, in_pix, fetch_trig, fetch_slot, fetch_sel;

    assign accept_req = (state == S_XFER) && wr_req;
    assign busy_fall  = busy_d2 && !busy_d1;
    assign last_sec   = (sec_cnt == LAST_SEC);
    assign in_pix     = (w >= 32'd27) && (w < PIX_END);
    assign fetch_trig = accept_req && ((w == 32'd26) ||
                        (in_pix && ph == 2'd2 && pair_cnt != LAST_PR));
    assign fetch_slot = (fetch_cnt != 2'd0);
    // Countdown 2 fills slot 0 (p0), countdown 1 fills slot 1 (p1).
    assign fetch_sel  = (fetch_cnt == 2'd1);

    function automatic logic [7:0] r8(input logic [15:0] p);
        return {p[15:11], p[15:13]};
    endfunction
    function automatic logic [7:0] g8(input logic [15:0] p);
        return {p[10:5], p[10:9]};
    endfunction
    function automatic logic [7:0] b8(input logic [15:0] p);
        return {p[4:0], p[4:2]};
    endfunction

`ifdef SD_WR_TESTPAT_EN
    localparam int BAR_W = IMG_W / 8;
    logic [31:0] col;

    function automatic logic [15:0] bar_color(input logic [31:0] c);
        logic [31:0] idx;
        idx = c / 32'(BAR_W);
        case (idx)
            32'd0:   return 16'hFFFF;
            32'd1:   return 16'hFFE0;
            32'd2:   return 16'h07FF;
            32'd3:   return 16'h07E0;
            32'd4:   return 16'hF81F;
            32'd5:   return 16'hF800;
            32'd6:   return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    assign pix_rd_en = 1'b0;
`else
    logic rd_pend, rd_sel;

    assign pix_rd_en = fetch_slot && !pix_empty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_START;
            S_START: next_state = S_XFER;
            S_XFER:  if (accept_req && wcnt == 8'd255) next_state = S_WAIT;
            S_WAIT:  if (busy_fall) next_state = last_sec ? S_DONE : S_START;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        wr_start_en = (state == S_START);
        busy        = (state != S_IDLE) && (state != S_DONE);
        done        = (state == S_DONE);
    end

    // Little-endian BMP header fields packed two bytes per word, first byte high.
    always_comb begin
        hdr_word = 16'h0000;
        case (w[4:0])
            5'd0:  hdr_word = 16'h424D;
            5'd1:  hdr_word = {FB32[7:0], FB32[15:8]};
            5'd2:  hdr_word = {FB32[23:16], FB32[31:24]};
            5'd5:  hdr_word = 16'h3600;
            5'd7:  hdr_word = 16'h2800;
            5'd9:  hdr_word = {W32[7:0], W32[15:8]};
            5'd10: hdr_word = {W32[23:16], W32[31:24]};
            5'd11: hdr_word = {H32[7:0], H32[15:8]};
            5'd12: hdr_word = {H32[23:16], H32[31:24]};
            5'd13: hdr_word = 16'h0100;
            5'd14: hdr_word = 16'h1800;
            5'd17: hdr_word = {PB32[7:0], PB32[15:8]};
            5'd18: hdr_word = {PB32[23:16], PB32[31:24]};
            default: hdr_word = 16'h0000;
        endcase
    end

    always_comb begin
        word_val = 16'h0000;
        if (w < 32'd27) begin
            word_val = hdr_word;
        end else if (in_pix) begin
            case (ph)
                2'd0:    word_val = {b8(stg0), g8(stg0)};
                2'd1:    word_val = {r8(stg0), b8(stg1)};
                default: word_val = {g8(stg1), r8(stg1)};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sec_addr   <= 32'd0;
            wr_data       <= 16'h0000;
            err_underflow <= 1'b0;
            sec_cnt       <= 32'd0;
            wcnt          <= 8'd0;
            w             <= 32'd0;
            ph            <= 2'd0;
            pair_cnt      <= 32'd0;
            fetch_cnt     <= 2'd0;
            stg0          <= 16'h0000;
            stg1          <= 16'h0000;
            busy_d1       <= 1'b0;
            busy_d2       <= 1'b0;
`ifdef SD_WR_TESTPAT_EN
            col           <= 32'd0;
`else
            rd_pend       <= 1'b0;
            rd_sel        <= 1'b0;
`endif
        end else begin
            busy_d1 <= wr_busy;
            busy_d2 <= busy_d1;

            if (state == S_IDLE && start) begin
                wr_sec_addr   <= sec_base;
                sec_cnt       <= 32'd0;
                wcnt          <= 8'd0;
                w             <= 32'd0;
                ph            <= 2'd0;
                pair_cnt      <= 32'd0;
                err_underflow <= 1'b0;
`ifdef SD_WR_TESTPAT_EN
                col           <= 32'd0;
`endif
            end

            if (state == S_WAIT && busy_fall && !last_sec) begin
                sec_cnt     <= sec_cnt + 32'd1;
                wr_sec_addr <= wr_sec_addr + 32'd1;
            end

            if (accept_req) begin
                wr_data <= word_val;
                w       <= w + 32'd1;
                wcnt    <= wcnt + 8'd1;
                if (in_pix) begin
                    if (ph == 2'd2) begin
                        ph       <= 2'd0;
                        pair_cnt <= pair_cnt + 32'd1;
                    end else begin
                        ph <= ph + 2'd1;
                    end
                end
            end

            if (fetch_trig)      fetch_cnt <= 2'd2;
            else if (fetch_slot) fetch_cnt <= fetch_cnt - 2'd1;

`ifdef SD_WR_TESTPAT_EN
            if (fetch_slot) begin
                if (fetch_sel) stg1 <= bar_color(col);
                else           stg0 <= bar_color(col);
                col <= (col == W32 - 32'd1) ? 32'd0 : col + 32'd1;
            end
`else
            // FIFO data lands one cycle after the strobe; an empty slot is zero-filled.
            rd_pend <= pix_rd_en;
            rd_sel  <= fetch_sel;
            if (rd_pend) begin
                if (rd_sel) stg1 <= pix_data;
                else        stg0 <= pix_data;
            end
            if (fetch_slot && pix_empty) begin
                if (fetch_sel) stg1 <= 16'h0000;
                else           stg0 <= 16'h0000;
                err_underflow <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sd_write_photo.sv
// Directed bench for sd_write_photo: a 640x480 instance for header/abort, a 16x12 instance for full frames.
`timescale 1ns/1ps
module tb_sd_write_photo;

    localparam int BW = 640;
    localparam int BH = 480;
    localparam int SW = 16;
    localparam int SH = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_b = 1'b0, start_s = 1'b0;
    logic [31:0] sec_base = 32'd0;
    logic        wr_busy = 1'b0, wr_req = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_empty = 1'b0;

    logic        wr_start_en_b, pix_rd_en_b, busy_b, done_b, err_b;
    logic [31:0] wr_sec_addr_b;
    logic [15:0] wr_data_b;
    logic        wr_start_en_s, pix_rd_en_s, busy_s, done_s, err_s;
    logic [31:0] wr_sec_addr_s;
    logic [15:0] wr_data_s;

    always #5 clk = ~clk;

    sd_write_photo #(.IMG_W(BW), .IMG_H(BH)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sec_base(sec_base),
        .wr_start_en(wr_start_en_b), .wr_sec_addr(wr_sec_addr_b), .wr_busy(wr_busy),
        .wr_req(wr_req), .wr_data(wr_data_b), .pix_rd_en(pix_rd_en_b), .pix_data(pix_data),
        .pix_empty(pix_empty), .busy(busy_b), .done(done_b), .err_underflow(err_b)
    );

    sd_write_photo #(.IMG_W(SW), .IMG_H(SH)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .sec_base(sec_base),
        .wr_start_en(wr_start_en_s), .wr_sec_addr(wr_sec_addr_s), .wr_busy(wr_busy),
        .wr_req(wr_req), .wr_data(wr_data_s), .pix_rd_en(pix_rd_en_s), .pix_data(pix_data),
        .pix_empty(pix_empty), .busy(busy_s), .done(done_s), .err_underflow(err_s)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] word_q[$];
    logic [31:0] addr_q[$];
    int  gw = 0, start_cnt = 0, rd_count = 0, rd_at_27 = -1, rd_bad = 0, pix_idx = 0;
    int  done_cnt_s = 0, done_busy_bad = 0;
    bit  use_big = 1'b1, uf_mode = 1'b0, prev_busy_s = 1'b0;

    logic [15:0] hdr_exp [27] = '{
        16'h424D, 16'h3610, 16'h0E00, 16'h0000, 16'h0000, 16'h3600, 16'h0000, 16'h2800,
        16'h0000, 16'h8002, 16'h0000, 16'hE001, 16'h0000, 16'h0100, 16'h1800, 16'h0000,
        16'h0000, 16'h0010, 16'h0E00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000
    };

    // ---------------- reference model ----------------
    function automatic logic [15:0] pix_val(int n, int w);
`ifdef SD_WR_TESTPAT_EN
        case ((n % w) / (w / 8))
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
`else
        if (n == 0) return 16'hF800;
        if (n == 1) return 16'h07E0;
        return 16'(n * 37 + 16'h1234) ^ 16'(n << 7);
`endif
    endfunction

    function automatic logic [7:0] file_byte(int b, int w, int h);
        int pb, fb, k;
        logic [15:0] p;
        pb = w * h * 3;
        fb = 54 + pb;
        if (b == 0) return 8'h42;
        if (b == 1) return 8'h4D;
        if (b >= 2 && b <= 5)   return 8'(fb >> (8 * (b - 2)));
        if (b == 10) return 8'd54;
        if (b == 14) return 8'd40;
        if (b >= 18 && b <= 21) return 8'(w >> (8 * (b - 18)));
        if (b >= 22 && b <= 25) return 8'(h >> (8 * (b - 22)));
        if (b == 26) return 8'd1;
        if (b == 28) return 8'd24;
        if (b >= 34 && b <= 37) return 8'(pb >> (8 * (b - 34)));
        if (b < 54 || b >= fb) return 8'h00;
        k = b - 54;
        p = pix_val(k / 3, w);
        case (k % 3)
            0:       return {p[4:0], p[4:2]};
            1:       return {p[10:5], p[10:9]};
            default: return {p[15:11], p[15:13]};
        endcase
    endfunction

    function automatic logic [15:0] exp_word(int wi, int w, int h);
        return {file_byte(2 * wi, w, h), file_byte(2 * wi + 1, w, h)};
    endfunction

    // ---------------- SD controller model ----------------
    initial begin : sd_model
        logic [15:0] got;
        forever begin
            @(negedge clk);
            if (rst_n && (wr_start_en_b || wr_start_en_s)) begin
                start_cnt++;
                addr_q.push_back(wr_start_en_b ? wr_sec_addr_b : wr_sec_addr_s);
                wr_busy = 1'b1;
                for (int i = 0; i < 256; i++) begin
                    repeat (3) @(negedge clk);
                    if (!rst_n) break;
                    if (uf_mode && gw == 176) pix_empty = 1'b1;
                    if (uf_mode && gw == 177) pix_empty = 1'b0;
                    wr_req = 1'b1;
                    @(negedge clk);
                    wr_req = 1'b0;
                    got = use_big ? wr_data_b : wr_data_s;
                    word_q.push_back(got);
                    if (gw == 27) rd_at_27 = rd_count;
                    gw++;
                end
                repeat (3) @(negedge clk);
                wr_busy = 1'b0;
            end
        end
    end

    // ---------------- pixel FIFO model (1-cycle read latency) ----------------
    initial begin : fifo_model
        forever begin
            @(negedge clk);
            #2;
            if (pix_rd_en_b || pix_rd_en_s) begin
                if (pix_empty) rd_bad++;
                @(posedge clk);
                #1;
                pix_data = pix_val(pix_idx, use_big ? BW : SW);
                pix_idx++;
                rd_count++;
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (done_s) begin
                done_cnt_s++;
                if (busy_s || !prev_busy_s) done_busy_bad++;
            end
            prev_busy_s = busy_s;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_run(input bit big);
        word_q.delete();
        addr_q.delete();
        gw = 0; start_cnt = 0; rd_count = 0; rd_at_27 = -1; rd_bad = 0; pix_idx = 0;
        done_cnt_s = 0; done_busy_bad = 0; pix_empty = 1'b0;
        use_big = big;
    endtask

    task automatic pulse_start(input bit big, input logic [31:0] base);
        @(negedge clk);
        sec_base = base;
        if (big) start_b = 1'b1; else start_s = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (word_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (word_q.size() >= n);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int c;
        c = 0;
        while (done_cnt_s == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (done_cnt_s != 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (wr_start_en_b !== 1'b0) begin fails++; $display("FAIL reset_start_en: got %0b want 0", wr_start_en_b); end
        tests++; if (wr_sec_addr_b !== 32'd0) begin fails++; $display("FAIL reset_sec_addr: got %0d want 0", wr_sec_addr_b); end
        tests++; if (wr_data_b !== 16'h0000) begin fails++; $display("FAIL reset_wr_data: got %h want 0000", wr_data_b); end
        tests++; if (pix_rd_en_b !== 1'b0) begin fails++; $display("FAIL reset_pix_rd_en: got %0b want 0", pix_rd_en_b); end
        tests++; if (busy_b !== 1'b0 || busy_s !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b/%0b want 0", busy_b, busy_s); end
        tests++; if (done_b !== 1'b0 || err_b !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %0b/%0b want 0", done_b, err_b); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_header();
        bit ok;
        logic [15:0] pix_exp [3];
        clear_run(1'b1);
        pulse_start(1'b1, 32'd10496);
        wait_words(30, 400, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL header_timeout: got %0d words want 30", word_q.size());
        end else begin
            tests++; if (addr_q[0] !== 32'd10496) begin fails++; $display("FAIL header_addr: got %0d want 10496", addr_q[0]); end
            for (int i = 0; i < 27; i++) begin
                tests++;
                if (word_q[i] !== hdr_exp[i]) begin fails++; $display("FAIL header_word%0d: got %h want %h", i, word_q[i], hdr_exp[i]); end
            end
`ifdef SD_WR_TESTPAT_EN
            pix_exp = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
            tests++; if (rd_count !== 0) begin fails++; $display("FAIL testpat_no_reads: got %0d want 0", rd_count); end
`else
            pix_exp = '{16'h0000, 16'hFF00, 16'hFF00};
            tests++; if (rd_at_27 !== 2) begin fails++; $display("FAIL prefetch_reads: got %0d want 2", rd_at_27); end
`endif
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (word_q[27 + i] !== pix_exp[i]) begin fails++; $display("FAIL pixel_word%0d: got %h want %h", 27 + i, word_q[27 + i], pix_exp[i]); end
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int c;
        c = 0;
        while (start_cnt < 6 && c < 8000) begin @(negedge clk); c++; end
        tests++;
        if (start_cnt < 6) begin
            fails++; $display("FAIL abort_reach_sector5: got %0d starts want 6", start_cnt);
        end else begin
            tests++; if (addr_q[5] !== 32'd10501) begin fails++; $display("FAIL abort_sector5_addr: got %0d want 10501", addr_q[5]); end
        end
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({wr_start_en_b, pix_rd_en_b, busy_b, done_b, err_b} !== 5'b0 || wr_sec_addr_b !== 32'd0 || wr_data_b !== 16'h0000) begin
            fails++; $display("FAIL abort_outputs: got addr=%0d data=%h busy=%0b want all 0", wr_sec_addr_b, wr_data_b, busy_b);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        clear_run(1'b1);
        pulse_start(1'b1, 32'd10496);
        wait_words(3, 100, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL abort_restart_timeout: got %0d words want 3", word_q.size());
        end else begin
            tests++; if (addr_q[0] !== 32'd10496) begin fails++; $display("FAIL abort_restart_addr: got %0d want 10496", addr_q[0]); end
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (word_q[i] !== hdr_exp[i]) begin fails++; $display("FAIL abort_restart_word%0d: got %h want %h", i, word_q[i], hdr_exp[i]); end
            end
        end
        pulse_reset();
    endtask

    task automatic test_full_frame();
        bit ok;
        int bad, nz, first_bad;
        clear_run(1'b0);
        pulse_start(1'b0, 32'd100);
        wait_words(50, 400, ok);
        pulse_start(1'b0, 32'd999);
        wait_done(4000, ok);
        repeat (20) @(negedge clk);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL frame_timeout: got %0d words want 512", word_q.size());
        end else begin
            tests++; if (start_cnt !== 2) begin fails++; $display("FAIL frame_sectors: got %0d want 2", start_cnt); end
            tests++; if (addr_q[0] !== 32'd100 || addr_q[1] !== 32'd101) begin fails++; $display("FAIL frame_addrs: got %0d,%0d want 100,101", addr_q[0], addr_q[1]); end
            tests++; if (word_q.size() !== 512) begin fails++; $display("FAIL frame_word_count: got %0d want 512", word_q.size()); end
            bad = 0; nz = 0; first_bad = -1;
            for (int i = 0; i < word_q.size() && i < 512; i++) begin
                if (word_q[i] !== exp_word(i, SW, SH)) begin bad++; if (first_bad < 0) first_bad = i; end
                if (i >= 315 && word_q[i] !== 16'h0000) nz++;
            end
            tests++;
            if (bad != 0) begin fails++; $display("FAIL frame_words: got %0d wrong words (first %0d: %h) want 0 (%h)", bad, first_bad, word_q[first_bad], exp_word(first_bad, SW, SH)); end
            tests++; if (nz != 0) begin fails++; $display("FAIL frame_pad: got %0d nonzero pad words want 0", nz); end
`ifdef SD_WR_TESTPAT_EN
            tests++; if (rd_count !== 0) begin fails++; $display("FAIL frame_reads: got %0d want 0", rd_count); end
`else
            tests++; if (rd_count !== SW * SH) begin fails++; $display("FAIL frame_reads: got %0d want %0d", rd_count, SW * SH); end
`endif
            tests++; if (done_cnt_s !== 1) begin fails++; $display("FAIL frame_done_pulses: got %0d want 1", done_cnt_s); end
            tests++; if (done_busy_bad !== 0) begin fails++; $display("FAIL frame_busy_at_done: got %0d bad want 0", done_busy_bad); end
            tests++; if (err_s !== 1'b0 || busy_s !== 1'b0) begin fails++; $display("FAIL frame_idle: got err=%0b busy=%0b want 0,0", err_s, busy_s); end
        end
    endtask

    task automatic test_underflow();
        bit ok;
        int bad;
        logic exp_err;
        clear_run(1'b0);
        uf_mode = 1'b1;
        pulse_start(1'b0, 32'd200);
        wait_done(4000, ok);
        uf_mode = 1'b0;
        repeat (10) @(negedge clk);
`ifdef SD_WR_TESTPAT_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        tests++;
        if (!ok) begin
            fails++; $display("FAIL uf_timeout: got %0d words want 512", word_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 177; i++) if (word_q[i] !== exp_word(i, SW, SH)) bad++;
            tests++; if (bad != 0) begin fails++; $display("FAIL uf_words_before: got %0d wrong want 0", bad); end
            for (int i = 177; i < 180; i++) begin
                tests++;
`ifdef SD_WR_TESTPAT_EN
                if (word_q[i] !== exp_word(i, SW, SH)) begin fails++; $display("FAIL uf_word%0d: got %h want %h", i, word_q[i], exp_word(i, SW, SH)); end
`else
                if (word_q[i] !== 16'h0000) begin fails++; $display("FAIL uf_word%0d: got %h want 0000", i, word_q[i]); end
`endif
            end
            tests++; if (err_s !== exp_err) begin fails++; $display("FAIL uf_err_sticky: got %0b want %0b", err_s, exp_err); end
            tests++; if (rd_bad !== 0) begin fails++; $display("FAIL uf_read_while_empty: got %0d want 0", rd_bad); end
`ifndef SD_WR_TESTPAT_EN
            tests++; if (rd_count !== SW * SH - 2) begin fails++; $display("FAIL uf_reads: got %0d want %0d", rd_count, SW * SH - 2); end
`endif
        end
        clear_run(1'b0);
        pulse_start(1'b0, 32'd300);
        tests++; if (err_s !== 1'b0 || busy_s !== 1'b1) begin fails++; $display("FAIL uf_cleared_by_start: got err=%0b busy=%0b want 0,1", err_s, busy_s); end
        pulse_reset();
    endtask

    initial begin
        test_reset();
        test_header();
        test_abort();
        test_full_frame();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
